// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
//   - opcode encodings understood by the attached combinational ALU
//   - FSM state type
//   - command record as stored in the command FIFO
// Optional feature macro: ALU_SEQ_CHAIN_EN adds a per-command chain bit.
package alu_seq_pkg;

  localparam logic [2:0] OP_OR        = 3'd0;
  localparam logic [2:0] OP_NAND      = 3'd1;
  localparam logic [2:0] OP_NOR       = 3'd2;
  localparam logic [2:0] OP_AND       = 3'd3;
  localparam logic [2:0] OP_ADD       = 3'd4;
  localparam logic [2:0] OP_SUB       = 3'd5;
  localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
`ifdef ALU_SEQ_CHAIN_EN
    logic       chain;
`endif
  } cmd_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for ALU commands.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_data    write request / data (ignored while full)
//   i_pop             read request (ignored while empty)
//   o_data            head entry (valid while !o_empty)
//   o_full, o_empty   status from registered pointers
// Pointers carry one extra wrap bit so full/empty differ only in the MSB.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the simple-ALU interface.
// Buffers commands in a FIFO, drives each onto the ALU instruction/data bus,
// holds the bus for SETTLE_CYCLES, captures the combinational result and
// returns it over a valid/ready response stream.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready            command handshake
//   i_cmd_op, i_cmd_a, i_cmd_b         opcode, operands (A -> data[7:4], B -> data[3:0])
//   i_cmd_chain                        (ALU_SEQ_CHAIN_EN only) B := low nibble of previous result
//   o_alu_instr, o_alu_data            ALU bus, {5'b0,op} and {a,b}
//   i_alu_result                       combinational ALU result
//   o_rsp_valid/i_rsp_ready            response handshake
//   o_rsp_result, o_rsp_op, o_rsp_err  response payload; err for opcodes 6/7
//   o_busy                             FIFO non-empty or FSM not idle
// Optional feature macro: ALU_SEQ_CHAIN_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [2:0] i_cmd_op,
  input  logic [3:0] i_cmd_a,
  input  logic [3:0] i_cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic       i_cmd_chain,
`endif
  output logic [7:0] o_alu_instr,
  output logic [7:0] o_alu_data,
  input  logic [7:0] i_alu_result,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_result,
  output logic [2:0] o_rsp_op,
  output logic       o_rsp_err,
  output logic       o_busy
);

  localparam int unsigned CMD_W       = $bits(cmd_t);
  localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_alu_instr;
  logic [7:0] r_alu_data;
  logic [7:0] r_rsp_result;
  logic [2:0] r_rsp_op;
  logic       r_rsp_err;

  cmd_t             w_cmd_in;
  cmd_t             w_head;
  logic [CMD_W-1:0] w_fifo_q;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_issue;
  logic             w_err_load;
  logic             w_capture;
  logic [3:0]       w_b_eff;

  always_comb begin
    w_cmd_in       = '0;
    w_cmd_in.op    = i_cmd_op;
    w_cmd_in.a     = i_cmd_a;
    w_cmd_in.b     = i_cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    w_cmd_in.chain = i_cmd_chain;
`endif
  end

  assign w_head = cmd_t'(w_fifo_q);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef ALU_SEQ_CHAIN_EN
  // Low nibble of the last response (0 after reset or after an errored op).
  logic [3:0] r_prev_nib;
  assign w_b_eff = w_head.chain ? r_prev_nib : w_head.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_prev_nib <= '0;
    else if (w_capture)  r_prev_nib <= i_alu_result[3:0];
    else if (w_err_load) r_prev_nib <= '0;
  end
`else
  assign w_b_eff = w_head.b;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_err_load  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // Illegal opcodes never reach the ALU bus; they answer directly.
          if (is_legal_op(w_head.op)) begin
            w_issue     = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_err_load  = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      ISSUE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_alu_instr  <= '0;
      r_alu_data   <= '0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_alu_instr <= {5'b0, w_head.op};
        r_alu_data  <= {w_head.a, w_b_eff};
        r_cnt       <= '0;
      end else if (r_state == ISSUE && !w_capture) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_result;
        r_rsp_op     <= r_alu_instr[2:0];
        r_rsp_err    <= 1'b0;
      end else if (w_err_load) begin
        r_rsp_result <= '0;
        r_rsp_op     <= w_head.op;
        r_rsp_err    <= 1'b1;
      end
    end
  end

  assign o_cmd_ready  = ~w_full;
  assign o_alu_instr  = r_alu_instr;
  assign o_alu_data   = r_alu_data;
  assign o_rsp_valid  = (r_state == RESP);
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a reference ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_valid = 1'b0;
  logic [2:0] r_op = '0;
  logic [3:0] r_a = '0;
  logic [3:0] r_b = '0;
  logic       r_chain = 1'b0;
  logic       r_rsp_ready = 1'b1;

  logic       o_cmd_ready;
  logic [7:0] o_alu_instr;
  logic [7:0] o_alu_data;
  logic [7:0] w_alu_res;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_result;
  logic [2:0] o_rsp_op;
  logic       o_rsp_err;
  logic       o_busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Reference ALU: operands zero-extended to 8 bits; opcodes 6/7 give junk.
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [7:0] xa, xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (op)
      3'd0:    return xa | xb;
      3'd1:    return ~(xa & xb);
      3'd2:    return ~(xa | xb);
      3'd3:    return xa & xb;
      3'd4:    return xa + xb;
      3'd5:    return xb - xa;
      default: return 8'hAA;
    endcase
  endfunction

  assign w_alu_res = alu_ref(o_alu_instr[2:0], o_alu_data[7:4], o_alu_data[3:0]);

  alu_cmd_sequencer #(
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (r_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (r_op),
    .i_cmd_a      (r_a),
    .i_cmd_b      (r_b),
`ifdef ALU_SEQ_CHAIN_EN
    .i_cmd_chain  (r_chain),
`endif
    .o_alu_instr  (o_alu_instr),
    .o_alu_data   (o_alu_data),
    .i_alu_result (w_alu_res),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (r_rsp_ready),
    .o_rsp_result (o_rsp_result),
    .o_rsp_op     (o_rsp_op),
    .o_rsp_err    (o_rsp_err),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         outstanding = 0;
  logic [7:0] prev_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
      prev_res    = '0;
      chk("rst_valid", o_rsp_valid, 0);
      chk("rst_busy", o_busy, 0);
    end else begin
      chk("busy", o_busy, outstanding != 0);
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", o_rsp_valid, 0);
        end else begin
          chk("rsp_result", o_rsp_result, exp_q[0].res);
          chk("rsp_op", o_rsp_op, exp_q[0].op);
          chk("rsp_err", o_rsp_err, exp_q[0].err);
          if (r_rsp_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
          end
        end
      end
      if (r_valid && o_cmd_ready) begin
        exp_t e;
        logic [3:0] b;
        b = r_b;
`ifdef ALU_SEQ_CHAIN_EN
        if (r_chain) b = prev_res[3:0];
`endif
        e.op  = r_op;
        e.err = (r_op > 3'd5);
        e.res = e.err ? 8'h00 : alu_ref(r_op, r_a, b);
        prev_res = e.res;
        exp_q.push_back(e);
        outstanding++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic chain);
    r_valid = 1'b1;
    r_op    = op;
    r_a     = a;
    r_b     = b;
    r_chain = chain;
  endtask

  // Push one command with the stream idle, wait for its response, check it
  // against literals, then let it be accepted.
  task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input logic [7:0] exp_res, input logic exp_err,
                         input int exp_lat);
    int cyc;
    r_rsp_ready = 1'b1;
    drive(op, a, b, chain);
    tick();
    r_valid = 1'b0;
    cyc = 1;
    while (!o_rsp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    if (!o_rsp_valid) chk("rsp_timeout", 0, 1);
    if (exp_lat != 0) chk("latency", cyc, exp_lat);
    chk("lit_result", o_rsp_result, exp_res);
    chk("lit_err", o_rsp_err, exp_err);
    chk("lit_op", o_rsp_op, op);
    tick();
  endtask

  task automatic push_five();
    logic [2:0] ops [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [3:0] as  [5] = '{4'hA, 4'h1, 4'hF, 4'h8, 4'h7};
    logic [3:0] bs  [5] = '{4'h5, 4'h2, 4'h6, 4'h8, 4'h3};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], 1'b0);
      chk("ready_before_push", o_cmd_ready, 1);
      tick();
    end
    r_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] instr_save, data_save;
    int cyc;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_ready", o_cmd_ready, 1);
    chk("reset_valid", o_rsp_valid, 0);
    chk("reset_result", o_rsp_result, 0);
    chk("reset_op", o_rsp_op, 0);
    chk("reset_err", o_rsp_err, 0);
    chk("reset_instr", o_alu_instr, 0);
    chk("reset_data", o_alu_data, 0);
    chk("reset_busy", o_busy, 0);
    rst_n = 1'b1;
    tick();

    // Single commands with literal expectations
    run_one(3'd4, 4'h9, 4'h7, 1'b0, 8'h10, 1'b0, 3);
    chk("instr_upper_zero", o_alu_instr, 8'h04);
    chk("data_bus", o_alu_data, 8'h97);
    run_one(3'd5, 4'h5, 4'h2, 1'b0, 8'hFD, 1'b0, 3);
    run_one(3'd1, 4'hF, 4'hF, 1'b0, 8'hF0, 1'b0, 3);
    run_one(3'd2, 4'h3, 4'h5, 1'b0, 8'hF8, 1'b0, 0);
    run_one(3'd3, 4'hC, 4'hA, 1'b0, 8'h08, 1'b0, 0);
    run_one(3'd0, 4'hC, 4'h3, 1'b0, 8'h0F, 1'b0, 0);
    run_one(3'd4, 4'hF, 4'hF, 1'b0, 8'h1E, 1'b0, 0);

    // Illegal opcodes: buses untouched, result forced to zero
    instr_save = o_alu_instr;
    data_save  = o_alu_data;
    run_one(3'd6, 4'h2, 4'h3, 1'b0, 8'h00, 1'b1, 2);
    chk("err_instr_hold", o_alu_instr, instr_save);
    chk("err_data_hold", o_alu_data, data_save);
    run_one(3'd7, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1, 2);

    // Back-pressure: 4 queued + 1 parked in RESP
    r_rsp_ready = 1'b0;
    push_five();
    chk("ready_low_full", o_cmd_ready, 0);
    drive(3'd4, 4'h1, 4'h1, 1'b0);
    tick();
    tick();
    r_valid = 1'b0;
    chk("ready_still_low", o_cmd_ready, 0);
    r_rsp_ready = 1'b1;
    cyc = 0;
    while (o_busy && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("drain_idle", o_busy, 0);
    chk("drain_all_rsp", exp_q.size(), 0);

    // Reset while ISSUE with 3 commands queued
    r_rsp_ready = 1'b0;
    push_five();
    r_rsp_ready = 1'b1;
    tick();
    r_rsp_ready = 1'b0;
    tick();
    chk("pre_reset_busy", o_busy, 1);
    chk("pre_reset_issue", o_rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", o_cmd_ready, 1);
    chk("midrst_valid", o_rsp_valid, 0);
    chk("midrst_instr", o_alu_instr, 0);
    chk("midrst_data", o_alu_data, 0);
    chk("midrst_result", o_rsp_result, 0);
    chk("midrst_op", o_rsp_op, 0);
    chk("midrst_err", o_rsp_err, 0);
    chk("midrst_busy", o_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    r_rsp_ready = 1'b1;
    repeat (8) tick();
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_valid", o_rsp_valid, 0);

`ifdef ALU_SEQ_CHAIN_EN
    run_one(3'd4, 4'h3, 4'h4, 1'b0, 8'h07, 1'b0, 3);
    run_one(3'd4, 4'h1, 4'hF, 1'b1, 8'h08, 1'b0, 3);
    run_one(3'd6, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1, 2);
    run_one(3'd0, 4'h5, 4'hF, 1'b1, 8'h05, 1'b0, 3);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the simple-ALU interface. Accepts ALU commands (opcode plus two nibble operands) over a valid/ready stream and buffers them in a small FIFO. It drives each command onto the ALU instruction/data bus, waits a settle cycle, captures the combinational result, and returns it with the opcode over an output valid/ready stream. Sits between the TT pin logic (switch/bidir capture) and the existing combinational ALU.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16
SETTLE_CYCLES, 1, cycles the bus is held stable before result capture; 1..7

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command offered
o_cmd_ready  out  1  FIFO can accept a command
i_cmd_op  in  3  ALU opcode: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB(b-a)
i_cmd_a  in  4  operand A; driven on ALU data[7:4]
i_cmd_b  in  4  operand B; driven on ALU data[3:0]
o_alu_instr  out  8  ALU instruction bus; {5'b0, op}
o_alu_data  out  8  ALU data bus; {a, b}
i_alu_result  in  8  ALU combinational result
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  downstream accepts response
o_rsp_result  out  8  captured result
o_rsp_op  out  3  opcode that produced the result
o_rsp_err  out  1  illegal opcode (6, 7); result forced to 0
o_busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values (async assert, sync release): FIFO empty; FSM IDLE; o_alu_instr=0, o_alu_data=0; o_rsp_valid=0, o_rsp_result=0, o_rsp_op=0, o_rsp_err=0; o_busy=0; o_cmd_ready=1.
- Cmd handshake: push on i_cmd_valid & o_cmd_ready. o_cmd_ready = !full, registered-count based. Pop and push may occur in the same cycle when full; the push is accepted only if ready was already high (no full-bypass).
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and register it onto the ALU buses; go to ISSUE. If the opcode is 6 or 7, skip ISSUE: load result 0 with err=1 and go to RESP.
  - ISSUE: count SETTLE_CYCLES cycles with buses stable. On the final count, capture i_alu_result into o_rsp_result and the opcode into o_rsp_op; go to RESP.
  - RESP: o_rsp_valid=1. Outputs stay stable until i_rsp_ready. On accept, go to IDLE. ALU buses keep the last command; they are not cleared.
- Latency: push to o_rsp_valid is a minimum of 2+SETTLE_CYCLES cycles (default 3) with the FIFO empty and the FSM idle. Throughput is one command per 2+SETTLE_CYCLES cycles with i_rsp_ready tied high.
- Arithmetic is done only by the ALU, which treats operands as 4-bit values zero-extended. ADD max 15+15=30 (0x1E). SUB b-a wraps 8-bit, e.g. 2-5 → 0xFD. The sequencer does not check the result.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB compare.
- Reset mid-operation: all state is discarded immediately; no response is emitted for in-flight or queued commands.
- Back-pressure: while in RESP, the FIFO keeps accepting commands until full.

Optional Feature:
ALU_SEQ_CHAIN_EN. When defined, the command has an extra input i_cmd_chain (1 bit), stored in the FIFO. When chain=1, operand B is replaced by the low nibble of the previous captured result, including an errored 0. After reset the previous result is 0. When the macro is undefined, the port is absent and B always comes from the command. All other timing is identical.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_OR..OP_SUB
  - OP_MAX_LEGAL=5
  - FSM state enum {IDLE, ISSUE, RESP}
  - command struct {op, a, b[, chain]}
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop, full/empty, async active-low reset.
- Top contains the FSM, settle counter and response registers.

Test Plan:
- Single cmd op=4 a=9 b=7 with a reference ALU attached → o_rsp_valid at cycle 3 after push; result 0x10, op=4, err=0.
- op=5 a=5 b=2 → result 0xFD; op=1 a=F b=F → result 0xF0. These check the 8-bit NAND on zero-extended operands.
- op=6 → o_rsp_valid with result 0x00, err=1; the ALU buses are not updated for this command.
- Push 5 cmds back-to-back with i_rsp_ready=0 → o_cmd_ready drops after the 4th accepted push, excluding the one popped into the FSM (4 queued + 1 in RESP). Responses then drain in order with correct opcodes.
- Assert rst_n low during ISSUE with 3 queued → all outputs return to reset values within the same cycle; no responses after release.
- (ALU_SEQ_CHAIN_EN) op=4 a=3 b=4 → 0x07, then chain op=4 a=1 → result 0x08.
